uart_time_parser: RTL and testbench
===================================

Name: uart_time_parser

Overview:
- Sits directly downstream of the UART receiver in the internet time-set path.
- Consumes received bytes and parses the ASCII time frame "THH:MM:SS\n".
- Range-checks the fields and emits a one-cycle load strobe with packed BCD hours/minutes/seconds for the clock counter.
- Malformed, out-of-range or stalled frames are dropped and flagged; the current time outputs are never corrupted.

Parameters:
- CLK_HZ, 50000000, system clock frequency; documentation only, for the TIMEOUT_CYCLES default.
- TIMEOUT_CYCLES, 500000, maximum idle gap between bytes inside a frame (10 ms at 50 MHz) before the frame is aborted.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
- time_load  output  1  one-cycle pulse; hour/min/sec outputs hold a new validated time.
- hour_bcd  output  8  tens digit in [7:4], units in [3:0]; range 00-23.
- min_bcd  output  8  BCD minutes; range 00-59.
- sec_bcd  output  8  BCD seconds; range 00-59.
- frame_err  output  1  one-cycle pulse when a frame is aborted.
- err_code  output  2  reason for the last abort: 0 bad char, 1 range, 2 timeout, 3 checksum. Holds until the next abort.
- busy  output  1  high while a frame is in progress (state is not IDLE).

Behaviour:
- Reset: all outputs 0, state IDLE, shadow registers 0, timeout counter 0.
- Bytes are processed only in cycles where rx_valid is high.
- CR (0x0D) is ignored in every state and does not reset the timeout counter.
- State sequence: IDLE -('T')-> H1 -> H0 -> C1(':') -> M1 -> M0 -> C2(':') -> S1 -> S0 -> [CK1 -> CK0 when CHECKSUM_EN] -> EOL('\n').
- In IDLE, any byte other than 'T' is silently discarded; it is not an error.
- Digit states accept only '0'-'9' (0x30-0x39). The digit value (byte - 0x30) is stored in a shadow nibble.
- Colon states accept only ':' (0x3A).
- 'T' received in any non-IDLE state restarts the frame: go to H1, discard the shadows, no error pulse.
- Any other unexpected byte: frame_err=1, err_code=0, state returns to IDLE.
- Range checks are applied at the digit where they become decidable:
  - H1 > 2: range error.
  - H0 when H1=2 and H0 > 3: range error.
  - M1 > 5 or S1 > 5: range error.
  - Range error sets err_code=1 and returns to IDLE.
- EOL: on '\n', the cycle after rx_valid is sampled:
  - time_load=1 for exactly one cycle.
  - hour_bcd/min_bcd/sec_bcd update from the shadows in that same cycle.
  - state returns to IDLE.
  - Latency is 1 clock from the '\n' strobe.
- A non-'\n' byte in EOL is a bad-char error.
- The time outputs change only on time_load. They hold their last valid value across errors.
- Timeout:
  - Counter clears on every accepted non-CR byte and counts while busy.
  - On reaching TIMEOUT_CYCLES: frame_err=1, err_code=2, state returns to IDLE.
  - If a byte arrives in the same cycle the timeout fires, the timeout wins and the byte is dropped.
- frame_err and time_load are never high in the same cycle.
- Reset asserted mid-frame aborts immediately with no pulses; outputs return to 0.

Optional Feature:
- Macro TIME_CHECKSUM_EN.
- When defined:
  - Two uppercase hex characters (0-9, A-F) follow S0.
  - Their value must equal the XOR of all frame bytes from 'T' through S0 inclusive.
  - A non-hex character is a bad-char error (err_code 0).
  - A mismatch, detected at CK0, is err_code 3; no load occurs.
- When undefined:
  - S0 goes straight to EOL.
  - The CK states, XOR accumulator and err_code 3 logic are not generated.
  - err_code 3 never occurs.

Test Plan:
- Frame "T12:34:56\n", one byte per 10 clocks -> one time_load pulse 1 clk after '\n'; hour_bcd=0x12, min_bcd=0x34, sec_bcd=0x56; busy low afterwards.
- Frame "T24:00:00\n" -> frame_err at H0 with err_code=1; outputs keep their prior value; the later '\n' produces no load.
- Frame "T12:3" then a pause longer than TIMEOUT_CYCLES -> frame_err with err_code=2 after exactly TIMEOUT_CYCLES idle clocks; a following "T01:02:03\r\n" loads 0x01/0x02/0x03.
- "T12:T23:59:59\n" -> resync with no error pulse; loads 0x23/0x59/0x59.
- "T12x34:56\n" -> err_code=0 at 'x'; reset asserted mid-frame on another frame -> all outputs 0, busy 0 asynchronously.
- With TIME_CHECKSUM_EN, "T00:00:00" plus the correct XOR hex and '\n' -> loads 00/00/00; the same frame with a checksum off by one bit -> err_code=3 and no load.

Source files
------------

// File: rtl/uart_time_parser.sv
// uart_time_parser
// Parses the ASCII time frame "THH:MM:SS\n" from the UART receiver byte stream.
// Each field is range-checked as soon as that check can be decided. A frame that
// completes cleanly produces a one-cycle time_load strobe with packed BCD time.
// A malformed, out-of-range or stalled frame is dropped and produces a one-cycle
// frame_err pulse. The time outputs change only on time_load.
//
// Optional feature: define TIME_CHECKSUM_EN to require two uppercase hex digits
// between S0 and '\n'. Their value must equal the XOR of the frame bytes from 'T'
// through S0 inclusive.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   one-cycle byte strobe
//   time_load  one-cycle pulse; hour/min/sec carry a new validated time
//   hour_bcd   BCD hours   00-23
//   min_bcd    BCD minutes 00-59
//   sec_bcd    BCD seconds 00-59
//   frame_err  one-cycle pulse when a frame is aborted
//   err_code   reason for the last abort: 0 char, 1 range, 2 timeout, 3 checksum
//   busy       a frame is in progress
module uart_time_parser #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_HZ / 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       time_load,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_H1, ST_H0, ST_C1, ST_M1, ST_M0, ST_C2, ST_S1, ST_S0,
`ifdef TIME_CHECKSUM_EN
        ST_CK1, ST_CK0,
`endif
        ST_EOL
    } state_t;

    localparam logic [7:0] CH_T     = 8'h54;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    localparam logic [1:0] ERR_CHAR    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
`ifdef TIME_CHECKSUM_EN
    localparam logic [1:0] ERR_CKSUM   = 2'd3;
`endif

    // The counter only needs to reach TIMEOUT_CYCLES-1. The timeout fires on the
    // TIMEOUT_CYCLES-th clock after the last accepted byte.
    localparam int unsigned  TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      h1_q, h1_d, h0_q, h0_d;
    logic [3:0]      m1_q, m1_d, m0_q, m0_d;
    logic [3:0]      s1_q, s1_d, s0_q, s0_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            time_load_q, time_load_d;
    logic [7:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
`ifdef TIME_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
    logic [3:0]      ck_hi_q, ck_hi_d;
    logic            is_hex;
    logic [3:0]      hex_val;
`endif

    logic            byte_in, is_digit, tmo_hit;
    logic [3:0]      digit;
    logic            ev_load, ev_err;
    logic [1:0]      ev_code;

    assign byte_in  = rx_valid && (rx_data != CH_CR);
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign digit    = rx_data[3:0];
    assign tmo_hit  = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);
`ifdef TIME_CHECKSUM_EN
    assign is_hex   = is_digit || ((rx_data >= 8'h41) && (rx_data <= 8'h46));
    assign hex_val  = rx_data[6] ? (rx_data[3:0] + 4'd9) : rx_data[3:0];
`endif

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            h1_q        <= '0;
            h0_q        <= '0;
            m1_q        <= '0;
            m0_q        <= '0;
            s1_q        <= '0;
            s0_q        <= '0;
            tmo_q       <= '0;
            time_load_q <= 1'b0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
`ifdef TIME_CHECKSUM_EN
            xor_q       <= '0;
            ck_hi_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            m1_q        <= m1_d;
            m0_q        <= m0_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            tmo_q       <= tmo_d;
            time_load_q <= time_load_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
`ifdef TIME_CHECKSUM_EN
            xor_q       <= xor_d;
            ck_hi_q     <= ck_hi_d;
`endif
        end
    end

    // Next state, shadow registers and frame events
    always_comb begin
        state_d = state_q;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        s1_d    = s1_q;
        s0_d    = s0_q;
        tmo_d   = (state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
        ev_load = 1'b0;
        ev_err  = 1'b0;
        ev_code = ERR_CHAR;
`ifdef TIME_CHECKSUM_EN
        xor_d   = xor_q;
        ck_hi_d = ck_hi_q;
`endif

        // The timeout is checked before the byte, so a byte in the firing cycle is dropped.
        if (tmo_hit) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
            ev_err  = 1'b1;
            ev_code = ERR_TIMEOUT;
        end else if (byte_in) begin
            tmo_d = '0;
            if (rx_data == CH_T) begin
                // 'T' always starts a fresh frame, even in the middle of one
                state_d = ST_H1;
                h1_d    = '0;
                h0_d    = '0;
                m1_d    = '0;
                m0_d    = '0;
                s1_d    = '0;
                s0_d    = '0;
`ifdef TIME_CHECKSUM_EN
                xor_d   = CH_T;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: state_d = ST_IDLE;
                    ST_H1: begin
                        if (!is_digit) ev_err = 1'b1;
                        else if (digit > 4'd2) begin
                            ev_err  = 1'b1;
                            ev_code = ERR_RANGE;
                        end else begin
                            h1_d    = digit;
                            state_d = ST_H0;
                        end
                    end
                    ST_H0: begin
                        if (!is_digit) ev_err = 1'b1;
                        else if ((h1_q == 4'd2) && (digit > 4'd3)) begin
                            ev_err  = 1'b1;
                            ev_code = ERR_RANGE;
                        end else begin
                            h0_d    = digit;
                            state_d = ST_C1;
                        end
                    end
                    ST_C1: begin
                        if (rx_data != CH_COLON) ev_err = 1'b1;
                        else state_d = ST_M1;
                    end
                    ST_M1: begin
                        if (!is_digit) ev_err = 1'b1;
                        else if (digit > 4'd5) begin
                            ev_err  = 1'b1;
                            ev_code = ERR_RANGE;
                        end else begin
                            m1_d    = digit;
                            state_d = ST_M0;
                        end
                    end
                    ST_M0: begin
                        if (!is_digit) ev_err = 1'b1;
                        else begin
                            m0_d    = digit;
                            state_d = ST_C2;
                        end
                    end
                    ST_C2: begin
                        if (rx_data != CH_COLON) ev_err = 1'b1;
                        else state_d = ST_S1;
                    end
                    ST_S1: begin
                        if (!is_digit) ev_err = 1'b1;
                        else if (digit > 4'd5) begin
                            ev_err  = 1'b1;
                            ev_code = ERR_RANGE;
                        end else begin
                            s1_d    = digit;
                            state_d = ST_S0;
                        end
                    end
                    ST_S0: begin
                        if (!is_digit) ev_err = 1'b1;
                        else begin
                            s0_d    = digit;
`ifdef TIME_CHECKSUM_EN
                            state_d = ST_CK1;
`else
                            state_d = ST_EOL;
`endif
                        end
                    end
`ifdef TIME_CHECKSUM_EN
                    ST_CK1: begin
                        if (!is_hex) ev_err = 1'b1;
                        else begin
                            ck_hi_d = hex_val;
                            state_d = ST_CK0;
                        end
                    end
                    ST_CK0: begin
                        if (!is_hex) ev_err = 1'b1;
                        else if ({ck_hi_q, hex_val} != xor_q) begin
                            ev_err  = 1'b1;
                            ev_code = ERR_CKSUM;
                        end else begin
                            state_d = ST_EOL;
                        end
                    end
`endif
                    ST_EOL: begin
                        if (rx_data != CH_LF) ev_err = 1'b1;
                        else begin
                            ev_load = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase

`ifdef TIME_CHECKSUM_EN
                if (state_q inside {ST_H1, ST_H0, ST_C1, ST_M1, ST_M0, ST_C2, ST_S1, ST_S0})
                    xor_d = xor_q ^ rx_data;
`endif
                if (ev_err) state_d = ST_IDLE;
            end
        end
    end

    // Registered outputs
    always_comb begin
        time_load_d = ev_load;
        frame_err_d = ev_err;
        err_code_d  = ev_err  ? ev_code      : err_code_q;
        hour_d      = ev_load ? {h1_q, h0_q} : hour_q;
        min_d       = ev_load ? {m1_q, m0_q} : min_q;
        sec_d       = ev_load ? {s1_q, s0_q} : sec_q;
        busy        = (state_q != ST_IDLE);
    end

    assign time_load = time_load_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign hour_bcd  = hour_q;
    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;

endmodule

// File: tb/tb_uart_time_parser.sv
// Testbench for uart_time_parser. A frame-level reference model tracks the bytes
// received since 'T' against the frame template. A per-cycle compare checks the
// DUT against that model. Literal checks pin the model to known answers.
module tb_uart_time_parser;

    localparam int unsigned TMO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       time_load, frame_err, busy;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] err_code;

    uart_time_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .time_load (time_load),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
`ifdef TIME_CHECKSUM_EN
    string tmpl = "THH:MM:SSXX\n";
`else
    string tmpl = "THH:MM:SS\n";
`endif
    bit           m_active;
    byte unsigned m_buf[$];
    int           m_gap;
    bit           m_load, m_err;
    logic [1:0]   m_code;
    logic [7:0]   m_hour, m_min, m_sec;
    int           cyc = 0;
    int           byte_cyc = 0;

    // DUT pulse bookkeeping
    int n_load = 0, n_err = 0, load_cyc = 0, err_cyc = 0;

    function automatic logic [3:0] nib(byte unsigned c);
        return c[3:0];
    endfunction

    function automatic logic [3:0] hexv(byte unsigned c);
        return (c > 8'h39) ? (c[3:0] + 4'd9) : c[3:0];
    endfunction

    function automatic void fire(logic [1:0] c);
        m_err    = 1'b1;
        m_code   = c;
        m_active = 1'b0;
        m_gap    = 0;
        m_buf.delete();
    endfunction

    function automatic void model_byte(byte unsigned b);
        int           pos = m_buf.size();
        byte unsigned k   = tmpl[pos];
        bit           dig = (b >= 8'h30) && (b <= 8'h39);
        bit           ok;
        byte unsigned x;
        case (k)
            8'h48, 8'h4D, 8'h53: ok = dig;                               // H M S
            8'h58:               ok = dig || (b >= 8'h41 && b <= 8'h46); // X
            default:             ok = (b == k);
        endcase
        if (!ok) begin
            fire(2'd0);
            return;
        end
        m_buf.push_back(b);
        if ((pos == 1 && b > 8'h32) || (pos == 2 && m_buf[1] == 8'h32 && b > 8'h33) ||
            ((pos == 4 || pos == 7) && b > 8'h35)) begin
            fire(2'd1);
            return;
        end
        if (pos == 10) begin
            x = 8'h00;
            for (int i = 0; i < 9; i++) x = x ^ m_buf[i];
            if (x != {hexv(m_buf[9]), hexv(b)}) begin
                fire(2'd3);
                return;
            end
        end
        if (k == 8'h0A) begin
            m_load   = 1'b1;
            m_hour   = {nib(m_buf[1]), nib(m_buf[2])};
            m_min    = {nib(m_buf[4]), nib(m_buf[5])};
            m_sec    = {nib(m_buf[7]), nib(m_buf[8])};
            m_active = 1'b0;
            m_buf.delete();
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_buf.delete();
            m_gap  = 0;
            m_load = 1'b0;
            m_err  = 1'b0;
            m_code = 2'd0;
            m_hour = 8'h00;
            m_min  = 8'h00;
            m_sec  = 8'h00;
        end else begin
            cyc++;
            m_load = 1'b0;
            m_err  = 1'b0;
            if (m_active && (m_gap + 1 >= TMO)) begin
                fire(2'd2);
            end else if (rx_valid && rx_data != 8'h0D) begin
                byte_cyc = cyc;
                if (rx_data == 8'h54) begin
                    m_buf.delete();
                    m_buf.push_back(8'h54);
                    m_active = 1'b1;
                    m_gap    = 0;
                end else if (m_active) begin
                    m_gap = 0;
                    model_byte(rx_data);
                end
            end else if (m_active) begin
                m_gap++;
            end
        end
    end

    always @(negedge clk) begin
        if (time_load) begin
            n_load++;
            load_cyc = cyc;
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(byte unsigned b, int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(string s, int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    n_checks++;
                    if ({time_load, frame_err, err_code, hour_bcd, min_bcd, sec_bcd, busy} !==
                        {m_load, m_err, m_code, m_hour, m_min, m_sec, m_active}) begin
                        n_fail++;
                        $display("FAIL model cyc=%0d: got load=%b err=%b code=%0d t=%h:%h:%h busy=%b expected load=%b err=%b code=%0d t=%h:%h:%h busy=%b",
                                 cyc, time_load, frame_err, err_code, hour_bcd, min_bcd, sec_bcd, busy,
                                 m_load, m_err, m_code, m_hour, m_min, m_sec, m_active);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({time_load, frame_err, err_code, hour_bcd, min_bcd, sec_bcd}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame
        send_str("T12:34:56\n", 9);
        check("f1_hour", 32'(hour_bcd), 32'h12);
        check("f1_min", 32'(min_bcd), 32'h34);
        check("f1_sec", 32'(sec_bcd), 32'h56);
        check("f1_loads", 32'(n_load), 32'd1);
        check("f1_latency", 32'(load_cyc - byte_cyc), 32'd0);
        check("f1_busy", 32'(busy), 32'h0);

        // Hour range error at H0
        send_str("T24:00:00\n", 9);
        check("rng_code", 32'(err_code), 32'd1);
        check("rng_errs", 32'(n_err), 32'd1);
        check("rng_hold", 32'(hour_bcd), 32'h12);
        check("rng_noload", 32'(n_load), 32'd1);

        // Stall, then a clean frame that contains a CR
        send_str("T12:3", 9);
        repeat (TMO + 5) @(negedge clk);
        check("tmo_code", 32'(err_code), 32'd2);
        check("tmo_cycles", 32'(err_cyc - byte_cyc), TMO);
        check("tmo_errs", 32'(n_err), 32'd2);
        send_str("T01:02:03", 4);
        send(8'h0D, 4);
        send(8'h0A, 9);
        check("cr_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h010203);
        check("cr_loads", 32'(n_load), 32'd2);

        // A byte in the firing cycle loses to the timeout. The rest of the frame is ignored while idle.
        send(8'h54, 9);
        send(8'h31, TMO - 1);
        send_str("2:00:00\n", 9);
        check("race_code", 32'(err_code), 32'd2);
        check("race_errs", 32'(n_err), 32'd3);
        check("race_noload", 32'(n_load), 32'd2);
        // One clock earlier the byte is accepted
        send(8'h54, 9);
        send(8'h31, TMO - 2);
        send_str("2:00:00\n", 9);
        check("near_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h120000);
        check("near_errs", 32'(n_err), 32'd3);

        // Resync on 'T' without an error
        send_str("T12:T23:59:59\n", 9);
        check("resync_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h235959);
        check("resync_errs", 32'(n_err), 32'd3);
        check("resync_loads", 32'(n_load), 32'd4);

        // Minute and second tens range errors
        send_str("T19:60:00\n", 9);
        check("min_rng_code", 32'(err_code), 32'd1);
        send_str("T20:00:60\n", 9);
        check("sec_rng_errs", 32'(n_err), 32'd5);

        // Bad character
        send_str("T12x34:56\n", 9);
        check("bad_code", 32'(err_code), 32'd0);
        check("bad_errs", 32'(n_err), 32'd6);
        check("bad_hold", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h235959);

`ifdef TIME_CHECKSUM_EN
        // XOR of "T00:00:00" is 0x54
        send_str("T00:00:0055\n", 9);
        check("ck_bad_code", 32'(err_code), 32'd3);
        check("ck_bad_noload", 32'(n_load), 32'd4);
        send_str("T00:00:0054\n", 9);
        check("ck_ok_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h000000);
        check("ck_ok_loads", 32'(n_load), 32'd5);
`endif

        // Asynchronous reset mid-frame
        send_str("T12:3", 4);
        check("mid_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_outputs", 32'({time_load, frame_err, err_code, hour_bcd, min_bcd, sec_bcd}), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
